dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the LSU load/store interface. Accepts one

---
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side LSU responder with latency model and byte-masked word array
// Optional YSYX_23060251_DMEM_RAND_DELAY_EN adds 0..3 LFSR-driven extra wait cycles per request.
module dmem_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                LATENCY     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_mask_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 4) + 1;
    localparam logic [ADDR_W:0] ADDR_LIM = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH_WORDS);
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt, lat_m1;
    logic              wen_q, signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        mask_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic              accept, commit, cur_wen, cur_signed, err;
    logic [ADDR_W-1:0] cur_addr, off;
    logic [7:0]        cur_mask;
    logic [DATA_W-1:0] cur_wdata, wd, sh, rd;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [IDX_W-1:0]  idx;
    assign req_ready_o  = state == IDLE;
    assign resp_valid_o = state == RESP;
    assign accept       = req_ready_o && req_valid_i;
`ifdef YSYX_23060251_DMEM_RAND_DELAY_EN
    logic [3:0] lfsr;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) lfsr <= 4'b1001;
        else if (accept) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    assign lat_m1 = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign lat_m1 = CNT_W'(LATENCY - 1);
`endif
    // A single-cycle latency commits on the accept edge itself, so use the live inputs then.
    always_comb begin
        cur_wen    = accept ? req_wen_i    : wen_q;
        cur_signed = accept ? req_signed_i : signed_q;
        cur_addr   = accept ? req_addr_i   : addr_q;
        cur_mask   = accept ? req_mask_i   : mask_q;
        cur_wdata  = accept ? req_wdata_i  : wdata_q;
        off  = cur_addr - BASE_ADDR;
        idx  = IDX_W'(off >> 2);
        lane = cur_addr[1:0];
        err  = {1'b0, cur_addr} >= ADDR_LIM || cur_addr < BASE_ADDR
            || !(cur_mask inside {8'h01, 8'h03, 8'h0F})
            || (cur_mask == 8'h03 && lane[0]) || (cur_mask == 8'h0F && lane != 2'd0);
        be   = 4'(cur_mask << lane);
        wd   = cur_wdata << {lane, 3'b000};
        sh   = mem[idx] >> {lane, 3'b000};
        rd   = cur_mask == 8'h01 ? {{24{cur_signed & sh[7]}}, sh[7:0]} :
               cur_mask == 8'h03 ? {{16{cur_signed & sh[15]}}, sh[15:0]} : sh;
        commit = (accept && lat_m1 == '0) || (state == WAIT && cnt == CNT_W'(1));
    end
    always_ff @(posedge clk_i)
        if (commit && cur_wen && !err && !rst_i)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            wen_q        <= 1'b0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                wen_q    <= req_wen_i;
                signed_q <= req_signed_i;
                addr_q   <= req_addr_i;
                mask_q   <= req_mask_i;
                wdata_q  <= req_wdata_i;
                cnt      <= lat_m1;
                state    <= lat_m1 == '0 ? RESP : WAIT;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state <= RESP;
            end else if (state == RESP && resp_ready_i) begin
                state <= IDLE;
            end
            if (commit) begin
                resp_rdata_o <= (cur_wen || err) ? '0 : rd;
                resp_err_o   <= err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two dmem_responder instances (LATENCY 1 and 4)
// against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    logic        clk_i = 1'b0;
    logic        rst_i [2], rv [2], rr [2], wen [2], sgn [2], vo [2], ro [2], eo [2];
    logic [31:0] addr [2], wdata [2], rdo [2];
    logic [7:0]  mask [2];
    logic [7:0]  bmem [longint];
    int          passed = 0, total = 0, fails = 0;
    always #5 clk_i = ~clk_i;
    dmem_responder #(.LATENCY(1)) u0 (
        .clk_i(clk_i), .rst_i(rst_i[0]), .req_valid_i(rv[0]), .req_ready_o(ro[0]),
        .req_wen_i(wen[0]), .req_signed_i(sgn[0]), .req_addr_i(addr[0]), .req_mask_i(mask[0]),
        .req_wdata_i(wdata[0]), .resp_valid_o(vo[0]), .resp_ready_i(rr[0]),
        .resp_rdata_o(rdo[0]), .resp_err_o(eo[0]));
    dmem_responder #(.LATENCY(4)) u1 (
        .clk_i(clk_i), .rst_i(rst_i[1]), .req_valid_i(rv[1]), .req_ready_o(ro[1]),
        .req_wen_i(wen[1]), .req_signed_i(sgn[1]), .req_addr_i(addr[1]), .req_mask_i(mask[1]),
        .req_wdata_i(wdata[1]), .resp_valid_o(vo[1]), .resp_ready_i(rr[1]),
        .resp_rdata_o(rdo[1]), .resp_err_o(eo[1]));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic longint key(input int k, input logic [31:0] a);
        return longint'({32'(k), a});
    endfunction
    // Reference: little-endian byte memory, sizes 1/2/4, natural alignment, bounded window.
    task automatic model(input int k, input logic w, input logic s, input logic [31:0] a,
                         input logic [7:0] m, input logic [31:0] d,
                         output logic [31:0] er, output logic ee);
        int sz;
        longint v;
        sz = m == 8'h01 ? 1 : m == 8'h03 ? 2 : m == 8'h0F ? 4 : 0;
        ee = sz == 0 || a < BASE || longint'(a) >= longint'(BASE) + 4 * 4096;
        if (sz != 0 && (a % sz) != 0) ee = 1'b1;
        er = '0;
        v  = 0;
        if (!ee && w)
            for (int i = 0; i < sz; i++) bmem[key(k, a + i)] = 8'(d >> (8 * i));
        if (!ee && !w) begin
            for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(bmem[key(k, a + i)]);
            if (s && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            er = 32'(v);
        end
    endtask
    task automatic txn(input int k, input logic w, input logic s, input logic [31:0] a,
                       input logic [7:0] m, input logic [31:0] d, input int hold,
                       output logic [31:0] got);
        logic [31:0] er;
        logic ee;
        int lat, lmin;
        model(k, w, s, a, m, d, er, ee);
        lmin = k ? 4 : 1;
        rv[k] = 1'b1; wen[k] = w; sgn[k] = s; addr[k] = a; mask[k] = m; wdata[k] = d;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
            wen[k] = 1'b1; sgn[k] = 1'($urandom_range(0, 1)); mask[k] = 8'h0F;
            addr[k] = BASE + 4 * $urandom_range(0, 7); wdata[k] = $urandom;
            if (!vo[k]) chk("busy_ready", 32'(ro[k]), 0);
        end while (!vo[k] && lat < 20);
`ifdef YSYX_23060251_DMEM_RAND_DELAY_EN
        chk("lat_range", 32'(lat >= lmin && lat <= lmin + 3), 1);
`else
        chk("latency", lat, lmin);
`endif
        got = rdo[k];
        chk("rdata", rdo[k], er);
        chk("err", 32'(eo[k]), 32'(ee));
        chk("resp_ready", 32'(ro[k]), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk("hold_valid", 32'(vo[k]), 1);
            chk("hold_rdata", rdo[k], er);
            chk("hold_ready", 32'(ro[k]), 0);
        end
        rr[k] = 1'b1;
        rv[k] = 1'b0;
        @(negedge clk_i);
        rr[k] = 1'b0;
        chk("done_valid", 32'(vo[k]), 0);
        chk("done_ready", 32'(ro[k]), 1);
    endtask
    task automatic rand_txn(input int k);
        logic [31:0] a, got;
        logic [7:0] m;
        int r;
        r = $urandom_range(0, 9);
        m = r < 3 ? 8'h01 : r < 6 ? 8'h03 : r < 9 ? 8'h0F : 8'($urandom);
        r = $urandom_range(0, 9);
        a = r == 0 ? 32'h7FFF_FFF0 + $urandom_range(0, 15) :
            r == 1 ? BASE + 16384 + $urandom_range(0, 15) : BASE + $urandom_range(0, 31);
        txn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, m, $urandom,
            $urandom_range(0, 3), got);
    endtask
    initial begin
        logic [31:0] got;
        for (int k = 0; k < 2; k++) begin
            rst_i[k] = 1'b1; rv[k] = 1'b0; rr[k] = 1'b0; wen[k] = 1'b0; sgn[k] = 1'b0;
            addr[k] = '0; mask[k] = '0; wdata[k] = '0;
        end
        repeat (2) @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(ro[k]), 1);
            chk("rst_valid", 32'(vo[k]), 0);
            chk("rst_rdata", rdo[k], 0);
            chk("rst_err", 32'(eo[k]), 0);
            rst_i[k] = 1'b0;
        end
        @(negedge clk_i);
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++) txn(k, 1'b1, 1'b0, BASE + 4 * j, 8'h0F, $urandom, 0, got);
        txn(0, 1'b1, 1'b0, 32'h8000_0010, 8'h0F, 32'hDEAD_BEEF, 0, got);
        txn(0, 1'b0, 1'b0, 32'h8000_0010, 8'h0F, 0, 0, got);
        chk("t1_word", got, 32'hDEAD_BEEF);
        txn(0, 1'b1, 1'b0, 32'h8000_0013, 8'h01, 32'h80, 0, got);
        txn(0, 1'b0, 1'b1, 32'h8000_0013, 8'h01, 0, 0, got);
        chk("t2_sbyte", got, 32'hFFFF_FF80);
        txn(0, 1'b0, 1'b0, 32'h8000_0013, 8'h01, 0, 1, got);
        chk("t2_ubyte", got, 32'h0000_0080);
        txn(0, 1'b0, 1'b0, 32'h8000_0010, 8'h0F, 0, 0, got);
        chk("t2_word", got, 32'h80AD_BEEF);
        txn(0, 1'b0, 1'b0, 32'h8000_0011, 8'h03, 0, 0, got);
        chk("t3_half_mis", got, 0);
        txn(0, 1'b1, 1'b0, 32'h7FFF_FFFC, 8'h0F, 32'h1111_2222, 0, got);
        txn(0, 1'b0, 1'b0, 32'h8000_0010, 8'h0F, 0, 0, got);
        chk("t3_unchanged", got, 32'h80AD_BEEF);
        txn(1, 1'b1, 1'b0, 32'h8000_0004, 8'h0F, 32'h0BAD_F00D, 2, got);
        txn(1, 1'b0, 1'b0, 32'h8000_0004, 8'h0F, 0, 5, got);
        chk("t4_word", got, 32'h0BAD_F00D);
        txn(1, 1'b1, 1'b0, 32'h8000_0020, 8'h0F, 32'hCAFE_F00D, 0, got);
        txn(1, 1'b0, 1'b0, 32'h8000_0020, 8'h0F, 0, 0, got);
        rv[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h8000_0020; mask[1] = 8'h0F; wdata[1] = 32'h1234_5678;
        @(negedge clk_i);
        rv[1] = 1'b0;
        chk("t5_wait_ready", 32'(ro[1]), 0);
        rst_i[1] = 1'b1;
        #1;
        chk("t5_rst_ready", 32'(ro[1]), 1);
        chk("t5_rst_valid", 32'(vo[1]), 0);
        chk("t5_rst_rdata", rdo[1], 0);
        chk("t5_rst_err", 32'(eo[1]), 0);
        @(negedge clk_i);
        rst_i[1] = 1'b0;
        @(negedge clk_i);
        txn(1, 1'b0, 1'b0, 32'h8000_0020, 8'h0F, 0, 0, got);
        chk("t5_prior", got, 32'hCAFE_F00D);
        repeat (40) rand_txn(0);
        repeat (40) rand_txn(1);
        for (int j = 0; j < 16; j++) txn(1, 1'b0, 1'b0, BASE + 4 * (j % 8), 8'h0F, 0, 0, got);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
